// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: WIDTH+1 edges from start to done, one op per WIDTH+2 cycles.
// start is ignored outside IDLE; optional signed-overflow output under SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_nxt;
    logic             last;

    assign s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nxt   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last    = (cnt == CW'(WIDTH - 1));
    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at position 0.
    assign res_nxt = (res_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with m.
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{m}};
                        carry <= m;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_nxt;
                    res_sr <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_nxt;
                        cout <= c_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the last bit, carry holds the carry into the MSB stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && last) begin
            ovf <= carry ^ c_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         m = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    // Hand-computed vectors, including the 0-0 and 1000-1000 corners.
    vec_t dv[10] = '{
        '{4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1},
        '{4'b1000, 4'b0100, 1'b0, 4'b1100, 1'b0, 1'b0},
        '{4'b1010, 4'b0010, 1'b0, 4'b1100, 1'b0, 1'b0},
        '{4'b1111, 4'b1010, 1'b1, 4'b0101, 1'b1, 1'b0},
        '{4'b1001, 4'b0100, 1'b1, 4'b0101, 1'b1, 1'b1},
        '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0},
        '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0},
        '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0},
        '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1},
        '{4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1}
    };

    logic [W-1:0] ha[10] = '{4'b1010, 4'b1111, 4'b0001, 4'b0110, 4'b1000,
                             4'b0011, 4'b0101, 4'b1110, 4'b0010, 4'b1011};
    logic [W-1:0] hb[10] = '{4'b0011, 4'b0111, 4'b1001, 4'b0100, 4'b1100,
                             4'b0110, 4'b0001, 4'b0101, 4'b1010, 4'b0000};
    logic         hm[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    exp_t         q[$];
    exp_t         mon_e;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mm, input int dcyc);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   t;
        int           sa;
        int           sb;
        int           r;
        bb    = mm ? ~mb : mb;
        t     = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mm};
        sa    = int'($signed(ma));
        sb    = int'($signed(mb));
        r     = mm ? (sa - sb) : (sa + sb);
        e.sum = t[W-1:0];
        e.cout = t[W];
        e.ovf = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
        e.cyc = dcyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_with_done", int'(busy && done), 0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("sum", int'(sum), int'(mon_e.sum));
                    chk("cout", int'(cout), int'(mon_e.cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                    chk("ovf", int'(ovf), int'(mon_e.ovf));
                    held_ovf = mon_e.ovf;
`endif
                    chk("done_latency", cyc, mon_e.cyc);
                    held_sum  = mon_e.sum;
                    held_cout = mon_e.cout;
                end
            end else begin
                chk("sum_hold", int'(sum), int'(held_sum));
                chk("cout_hold", int'(cout), int'(held_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("ovf_hold", int'(ovf), int'(held_ovf));
`endif
            end
        end else begin
            held_sum  = '0;
            held_cout = 1'b0;
            held_ovf  = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (n < 100 && !(q.size() == 0 && !busy && !done)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    // Called at a negedge with the DUT idle; scrambles operands after the start edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                         input exp_t e);
        exp_t x;
        x     = e;
        x.cyc = cyc + 1 + W;
        a     = ta;
        b     = tb_v;
        m     = tm;
        start = 1'b1;
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        m     = ~tm;
        wait_idle();
    endtask

    task automatic issue_vec(input vec_t v);
        exp_t e;
        e.sum  = v.s;
        e.cout = v.c;
        e.ovf  = v.o;
        e.cyc  = 0;
        issue(v.a, v.b, v.m, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sum", int'(sum), 0);
        chk("reset_cout", int'(cout), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("reset_ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dv[i]) issue_vec(dv[i]);

        // start held high with changing operands: accepted only at i=0 and i=W+2
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            a     = ha[i];
            b     = hb[i];
            m     = hm[i];
            start = 1'b1;
            if (i == 0 || i == W + 2) q.push_back(model(ha[i], hb[i], hm[i], cyc + 1 + W));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // reset in the second SHIFT cycle aborts with no done pulse
        a     = 4'b0111;
        b     = 4'b0001;
        m     = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sum", int'(sum), 0);
        chk("abort_cout", int'(cout), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("abort_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        issue_vec('{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1});

        for (int mm = 0; mm < 2; mm++) begin
            for (int aa = 0; aa < 16; aa++) begin
                for (int bb = 0; bb < 16; bb++) begin
                    issue(W'(aa), W'(bb), mm[0], model(W'(aa), W'(bb), mm[0], 0));
                end
            end
        end

        wait_idle();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
